// File: rtl/ex_pc_calculation_if.sv
// ---------------------------------------------------------------------------
// ex_pc_calculation_if
//   Operand/result bundle for the EX-stage branch-target adder.
//
//   Handshake: there is no ready/back-pressure. valid_in qualifies PC_in and
//   offset in the cycle it is high; valid_out qualifies PC_out and the two
//   flags. A new operand may be presented every cycle.
//
//   Signals
//     valid_in    master->slave  operands valid this cycle
//     PC_in       master->slave  PC+4 of the branch instruction
//     offset      master->slave  sign-extended word offset
//     valid_out   slave->master  results valid
//     PC_out      slave->master  branch target address
//     misaligned  slave->master  PC_in[1:0] != 0
//     shift_ovf   slave->master  the <<2 dropped significant offset bits
//   Modports: master (operand producer / bench), slave (the adder).
// ---------------------------------------------------------------------------
interface ex_pc_calculation_if #(
  parameter int WIDTH = 32
);
  logic             valid_in;
  logic [WIDTH-1:0] PC_in;
  logic [WIDTH-1:0] offset;
  logic             valid_out;
  logic [WIDTH-1:0] PC_out;
  logic             misaligned;
  logic             shift_ovf;

  modport master (
    output valid_in,
    output PC_in,
    output offset,
    input  valid_out,
    input  PC_out,
    input  misaligned,
    input  shift_ovf
  );

  modport slave (
    input  valid_in,
    input  PC_in,
    input  offset,
    output valid_out,
    output PC_out,
    output misaligned,
    output shift_ovf
  );
endinterface

// File: rtl/ex_pc_calculation.sv
// ---------------------------------------------------------------------------
// ex_pc_calculation
//   EX-stage branch-target adder of the 5-stage MIPS pipeline:
//     PC_out = (PC_in + {offset[29:0], 2'b00}) mod 2^32
//   The carry-out is discarded, so wrap-around is silent. PC_out[1:0] always
//   equals PC_in[1:0]. Two informational flags never alter PC_out:
//     misaligned  PC_in[1:0] != 2'b00
//     shift_ovf   offset[31:29] not all equal (shift lost significant bits)
//   Both flags read 0 whenever valid_out is 0.
//
//   Ports
//     clk    rising-edge clock (used only with EX_PC_CALC_OUT_REG_EN)
//     rst_n  synchronous active-low reset (used only with EX_PC_CALC_OUT_REG_EN)
//     bus    ex_pc_calculation_if.slave: valid_in, PC_in, offset in;
//            valid_out, PC_out, misaligned, shift_ovf out
//
//   Configuration macro: EX_PC_CALC_OUT_REG_EN
//     undefined: outputs are combinational, valid_out = valid_in, PC_out is
//                computed regardless of valid_in, clk/rst_n are ignored.
//     defined:   all four outputs are registered (1-cycle latency). PC_out
//                and the flags load only when valid_in=1, otherwise hold;
//                valid_out is valid_in delayed one cycle; reset clears all
//                outputs and wins over a simultaneous valid_in.
//   WIDTH: only 32 is supported.
// ---------------------------------------------------------------------------
module ex_pc_calculation #(
  parameter int WIDTH = 32
) (
  input logic                clk,
  input logic                rst_n,
  ex_pc_calculation_if.slave bus
);

  logic [WIDTH-1:0] shifted;
  logic [WIDTH-1:0] sum;
  logic             mis_c;
  logic             ovf_c;
  logic [2:0]       off_top;

  // Datapath shared by both builds.
  always_comb begin
    shifted = {bus.offset[WIDTH-3:0], 2'b00};
    sum     = bus.PC_in + shifted;            // carry-out intentionally dropped
    mis_c   = |bus.PC_in[1:0];
    off_top = bus.offset[WIDTH-1:WIDTH-3];
    // The shift preserves the signed value only if bits 31:29 are sign copies.
    ovf_c   = (off_top != 3'b000) && (off_top != 3'b111);
  end

`ifdef EX_PC_CALC_OUT_REG_EN

  logic [WIDTH-1:0] pc_q,    pc_d;
  logic             mis_q,   mis_d;
  logic             ovf_q,   ovf_d;
  logic             valid_q, valid_d;

  always_comb begin
    pc_d    = pc_q;
    mis_d   = mis_q;
    ovf_d   = ovf_q;
    valid_d = bus.valid_in;
    if (bus.valid_in) begin
      pc_d  = sum;
      mis_d = mis_c;
      ovf_d = ovf_c;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc_q    <= '0;
      mis_q   <= 1'b0;
      ovf_q   <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      pc_q    <= pc_d;
      mis_q   <= mis_d;
      ovf_q   <= ovf_d;
      valid_q <= valid_d;
    end
  end

  // Held flag values must not leak out while no result is being presented.
  assign bus.valid_out  = valid_q;
  assign bus.PC_out     = pc_q;
  assign bus.misaligned = mis_q & valid_q;
  assign bus.shift_ovf  = ovf_q & valid_q;

`else

  // Clock and reset have no function in the combinational build.
  logic unused_clk_rst;
  assign unused_clk_rst = clk ^ rst_n;

  assign bus.valid_out  = bus.valid_in;
  assign bus.PC_out     = sum;
  assign bus.misaligned = mis_c & bus.valid_in;
  assign bus.shift_ovf  = ovf_c & bus.valid_in;

`endif

endmodule

// File: tb/tb_ex_pc_calculation.sv
// ---------------------------------------------------------------------------
// tb_ex_pc_calculation
//   Directed bench for ex_pc_calculation. Works for both the combinational
//   build and the EX_PC_CALC_OUT_REG_EN registered build; expected values are
//   hand-computed constants.
// ---------------------------------------------------------------------------
module tb_ex_pc_calculation;

  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_fail;
  logic [31:0] last_pc;   // last PC_out loaded, for hold checks

  ex_pc_calculation_if #(.WIDTH(32)) bus ();

  ex_pc_calculation #(.WIDTH(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- driver tasks ----------------
  task automatic drive(input logic v, input logic [31:0] pc, input logic [31:0] off);
    @(negedge clk);
    bus.valid_in = v;
    bus.PC_in    = pc;
    bus.offset   = off;
  endtask

  // Wait until the result of the operands just driven is visible.
  task automatic settle();
`ifdef EX_PC_CALC_OUT_REG_EN
    @(posedge clk);
    #1;
`else
    #1;
`endif
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n = 1'b0;
    drive(1'b1, 32'h4, 32'h2);   // valid alongside reset
    settle();
`ifdef EX_PC_CALC_OUT_REG_EN
    n_cmp++; if (bus.valid_out !== 1'b0) begin n_fail++; $display("FAIL reset_valid got=%b exp=0", bus.valid_out); end
    n_cmp++; if (bus.PC_out !== 32'h0) begin n_fail++; $display("FAIL reset_pc got=%h exp=00000000", bus.PC_out); end
    n_cmp++; if (bus.misaligned !== 1'b0) begin n_fail++; $display("FAIL reset_mis got=%b exp=0", bus.misaligned); end
    n_cmp++; if (bus.shift_ovf !== 1'b0) begin n_fail++; $display("FAIL reset_ovf got=%b exp=0", bus.shift_ovf); end
    last_pc = 32'h0;
`else
    // Reset has no effect in the combinational build.
    n_cmp++; if (bus.valid_out !== 1'b1) begin n_fail++; $display("FAIL reset_comb_valid got=%b exp=1", bus.valid_out); end
    n_cmp++; if (bus.PC_out !== 32'h0000000C) begin n_fail++; $display("FAIL reset_comb_pc got=%h exp=0000000c", bus.PC_out); end
`endif
    rst_n = 1'b1;
  endtask

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] off;
    logic [31:0] exp_pc;
    logic        exp_mis;
    logic        exp_ovf;
  } vec_t;

  // Back-to-back valid operands, one per cycle.
  task automatic test_vectors();
    vec_t vecs [10];
    vecs = '{
      '{32'h00000004, 32'h00000002, 32'h0000000C, 1'b0, 1'b0},
      '{32'h00000000, 32'h00000004, 32'h00000010, 1'b0, 1'b0},
      '{32'h00000100, 32'hFFFFFFFF, 32'h000000FC, 1'b0, 1'b0},
      '{32'hFFFFFFFC, 32'h00000001, 32'h00000000, 1'b0, 1'b0},
      '{32'h00000006, 32'h00000000, 32'h00000006, 1'b1, 1'b0},
      '{32'h00001000, 32'h40000000, 32'h00001000, 1'b0, 1'b1},
      '{32'h00001000, 32'hE0000000, 32'h80001000, 1'b0, 1'b0},
      '{32'h00000003, 32'h80000000, 32'h00000003, 1'b1, 1'b1},
      '{32'h00000400, 32'h20000000, 32'h80000400, 1'b0, 1'b1},
      '{32'h00000400, 32'hFFFFFFF0, 32'h000003C0, 1'b0, 1'b0}
    };
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, vecs[i].pc, vecs[i].off);
      settle();
      n_cmp++; if (bus.valid_out !== 1'b1) begin n_fail++; $display("FAIL vec%0d_valid got=%b exp=1", i, bus.valid_out); end
      n_cmp++; if (bus.PC_out !== vecs[i].exp_pc) begin n_fail++; $display("FAIL vec%0d_pc got=%h exp=%h", i, bus.PC_out, vecs[i].exp_pc); end
      n_cmp++; if (bus.misaligned !== vecs[i].exp_mis) begin n_fail++; $display("FAIL vec%0d_mis got=%b exp=%b", i, bus.misaligned, vecs[i].exp_mis); end
      n_cmp++; if (bus.shift_ovf !== vecs[i].exp_ovf) begin n_fail++; $display("FAIL vec%0d_ovf got=%b exp=%b", i, bus.shift_ovf, vecs[i].exp_ovf); end
      last_pc = vecs[i].exp_pc;
    end
  endtask

  // Flags must read 0 without valid; PC_out computes (comb) or holds (reg).
  task automatic test_valid_qualify();
    drive(1'b1, 32'h00000007, 32'h40000000);  // PC_out 7, mis=1, ovf=1
    settle();
    n_cmp++; if ((bus.misaligned !== 1'b1) || (bus.shift_ovf !== 1'b1)) begin
      n_fail++; $display("FAIL qual_flags_on got=%b%b exp=11", bus.misaligned, bus.shift_ovf);
    end
    last_pc = 32'h00000007;
    drive(1'b0, 32'h00000006, 32'h40000001);
    settle();
    n_cmp++; if (bus.valid_out !== 1'b0) begin n_fail++; $display("FAIL qual_valid got=%b exp=0", bus.valid_out); end
    n_cmp++; if (bus.misaligned !== 1'b0) begin n_fail++; $display("FAIL qual_mis got=%b exp=0", bus.misaligned); end
    n_cmp++; if (bus.shift_ovf !== 1'b0) begin n_fail++; $display("FAIL qual_ovf got=%b exp=0", bus.shift_ovf); end
`ifdef EX_PC_CALC_OUT_REG_EN
    n_cmp++; if (bus.PC_out !== last_pc) begin n_fail++; $display("FAIL qual_pc_hold got=%h exp=%h", bus.PC_out, last_pc); end
    // Holding stays across a second idle cycle, then a valid load resumes.
    drive(1'b0, 32'h00000010, 32'h00000010);
    settle();
    n_cmp++; if (bus.PC_out !== last_pc) begin n_fail++; $display("FAIL qual_pc_hold2 got=%h exp=%h", bus.PC_out, last_pc); end
`else
    // 0x6 + (0x40000001<<2 = 0x4) = 0xA, computed even without valid
    n_cmp++; if (bus.PC_out !== 32'h0000000A) begin n_fail++; $display("FAIL qual_pc_comb got=%h exp=0000000a", bus.PC_out); end
`endif
    drive(1'b1, 32'h00000008, 32'h00000003);
    settle();
    n_cmp++; if ((bus.valid_out !== 1'b1) || (bus.PC_out !== 32'h00000014)) begin
      n_fail++; $display("FAIL qual_resume got=%b/%h exp=1/00000014", bus.valid_out, bus.PC_out);
    end
  endtask

`ifdef EX_PC_CALC_OUT_REG_EN
  // Latency is exactly one cycle and reset drops an in-flight result.
  task automatic test_latency_reset();
    drive(1'b0, 32'h0, 32'h0);
    settle();
    drive(1'b1, 32'h00000004, 32'h00000002);
    #1;
    n_cmp++; if (bus.valid_out !== 1'b0) begin n_fail++; $display("FAIL lat_early got=%b exp=0", bus.valid_out); end
    settle();
    n_cmp++; if ((bus.valid_out !== 1'b1) || (bus.PC_out !== 32'h0000000C)) begin
      n_fail++; $display("FAIL lat_one got=%b/%h exp=1/0000000c", bus.valid_out, bus.PC_out);
    end
    drive(1'b1, 32'h00000005, 32'h40000000);
    rst_n = 1'b0;
    settle();
    n_cmp++; if ((bus.valid_out !== 1'b0) || (bus.PC_out !== 32'h0) || (bus.misaligned !== 1'b0) || (bus.shift_ovf !== 1'b0)) begin
      n_fail++; $display("FAIL mid_reset got=%b/%h/%b%b exp=0/00000000/00", bus.valid_out, bus.PC_out, bus.misaligned, bus.shift_ovf);
    end
    rst_n = 1'b1;
    drive(1'b0, 32'h0, 32'h0);
    settle();
    n_cmp++; if ((bus.valid_out !== 1'b0) || (bus.PC_out !== 32'h0)) begin
      n_fail++; $display("FAIL post_reset got=%b/%h exp=0/00000000", bus.valid_out, bus.PC_out);
    end
  endtask
`endif

  // ---------------- sequence + report ----------------
  initial begin
    n_cmp        = 0;
    n_fail       = 0;
    last_pc      = 32'h0;
    rst_n        = 1'b1;
    bus.valid_in = 1'b0;
    bus.PC_in    = 32'h0;
    bus.offset   = 32'h0;
    test_reset();
    test_vectors();
    test_valid_qualify();
`ifdef EX_PC_CALC_OUT_REG_EN
    test_latency_reset();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
